// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like request/response channel shared by the fetch, execute and bus ports.
// The master drives the request fields; the slave answers with addr_ok/data_ok/rdata.
interface sram_bus_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-like bus arbiter with data priority,
// grant hold until accept, and an in-order owner FIFO for response routing.
module sram_bus_arbiter #(
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    sram_bus_arbiter_if.slave             inst,
    sram_bus_arbiter_if.slave             data,
    sram_bus_arbiter_if.master            bus,
    output logic [$clog2(OUTSTANDING):0]  outstanding,
    output logic                          orphan_err
);

    localparam int unsigned PW = $clog2(OUTSTANDING);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_I,
        HOLD_D
    } state_e;

    state_e                 state_q, state_d;
    logic [OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   orphan_q, orphan_d;

    logic full, empty;
    logic sel_i, sel_d;
    logic push, pop;
    logic head_is_d;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

    // A held grant stays frozen even if the other master requests.
    always_comb begin
        sel_i = 1'b0;
        sel_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!full) begin
                    sel_d = data.req;
                    sel_i = !data.req && inst.req;
                end
            end
            HOLD_I:  sel_i = 1'b1;
            HOLD_D:  sel_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.req   = !full & ((sel_d & data.req) | (sel_i & inst.req));
    assign bus.wr    = (sel_d & data.wr) | (sel_i & inst.wr);
    assign bus.size  = ({2{sel_d}} & data.size) | ({2{sel_i}} & inst.size);
    assign bus.wstrb = ({4{sel_d}} & data.wstrb) | ({4{sel_i}} & inst.wstrb);
    assign bus.addr  = ({32{sel_d}} & data.addr) | ({32{sel_i}} & inst.addr);
    assign bus.wdata = ({32{sel_d}} & data.wdata) | ({32{sel_i}} & inst.wdata);

    assign inst.addr_ok = bus.addr_ok & bus.req & sel_i;
    assign data.addr_ok = bus.addr_ok & bus.req & sel_d;

    assign push      = bus.req & bus.addr_ok;
    assign pop       = bus.data_ok & !empty;
    assign head_is_d = fifo_q[head_q];

    assign inst.data_ok = pop & !head_is_d;
    assign data.data_ok = pop & head_is_d;
    assign inst.rdata   = bus.rdata;
    assign data.rdata   = bus.rdata;

    assign outstanding = cnt_q;
    assign orphan_err  = orphan_q;

    always_comb begin
        fifo_d   = fifo_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        orphan_d = orphan_q | (bus.data_ok & empty);
        if (push) begin
            fifo_d[tail_q] = sel_d;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sel_d && !bus.addr_ok) begin
                    state_d = HOLD_D;
                end else if (sel_i && !bus.addr_ok) begin
                    state_d = HOLD_I;
                end
            end
            HOLD_I, HOLD_D: begin
                if (bus.addr_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            fifo_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fifo_q   <= fifo_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            orphan_q <= orphan_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_sram_bus_arbiter;

    localparam int OUT = 4;
    localparam logic [31:0] IA = 32'h0000_1000;
    localparam logic [31:0] DA = 32'h0000_2000;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] outstanding;
    logic       orphan_err;

    always #5 clk = ~clk;

    sram_bus_arbiter_if inst_if ();
    sram_bus_arbiter_if data_if ();
    sram_bus_arbiter_if bus_if ();

    sram_bus_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .inst        (inst_if),
        .data        (data_if),
        .bus         (bus_if),
        .outstanding (outstanding),
        .orphan_err  (orphan_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit ir, bit dr, bit aok, bit dok, logic [31:0] rd);
        inst_if.req    = ir;
        data_if.req    = dr;
        bus_if.addr_ok = aok;
        bus_if.data_ok = dok;
        bus_if.rdata   = rd;
    endtask

    task automatic set_fields();
        inst_if.wr = 1'b0; inst_if.size = 2'd2; inst_if.wstrb = 4'hf;
        inst_if.addr = IA; inst_if.wdata = 32'h0;
        data_if.wr = 1'b1; data_if.size = 2'd1; data_if.wstrb = 4'h3;
        data_if.addr = DA; data_if.wdata = 32'hdead_beef;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0);
        cyc();
        cyc();
        rstn = 1'b1;
    endtask

    typedef struct {
        bit          ir, dr, aok, dok;
        logic [31:0] rd;
        bit          breq;
        logic [31:0] baddr;
        bit          iaok, daok, idok, ddok;
        int          out;
    } vec_t;

    vec_t tv[12];

    // Reference model state
    bit q[$];
    int lock;
    bit m_orphan;

    initial begin
        rstn = 1'b0;
        set_fields();
        drive(0, 0, 0, 0, 0);
        do_reset();
        #2;
        chk("rst_bus_req", bus_if.req, 0);
        chk("rst_bus_addr", bus_if.addr, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_orphan", orphan_err, 0);
        chk("rst_oks", {inst_if.addr_ok, data_if.addr_ok,
                        inst_if.data_ok, data_if.data_ok}, 0);

        //        ir dr ak dk rd     breq baddr iaok daok idok ddok out
        tv[0]  = '{0, 0, 0, 0, 32'h0,  0, 0,  0, 0, 0, 0, 0};
        tv[1]  = '{1, 0, 1, 0, 32'h0,  1, IA, 1, 0, 0, 0, 0};
        tv[2]  = '{0, 1, 1, 0, 32'h0,  1, DA, 0, 1, 0, 0, 1};
        tv[3]  = '{1, 0, 1, 0, 32'h0,  1, IA, 1, 0, 0, 0, 2};
        tv[4]  = '{0, 0, 0, 1, 32'h11, 0, 0,  0, 0, 1, 0, 3};
        tv[5]  = '{0, 0, 0, 1, 32'h22, 0, 0,  0, 0, 0, 1, 2};
        tv[6]  = '{0, 0, 0, 1, 32'h33, 0, 0,  0, 0, 1, 0, 1};
        tv[7]  = '{1, 1, 1, 0, 32'h0,  1, DA, 0, 1, 0, 0, 0};
        tv[8]  = '{1, 0, 1, 0, 32'h0,  1, IA, 1, 0, 0, 0, 1};
        tv[9]  = '{0, 0, 0, 1, 32'h55, 0, 0,  0, 0, 0, 1, 2};
        tv[10] = '{0, 0, 0, 1, 32'h66, 0, 0,  0, 0, 1, 0, 1};
        tv[11] = '{0, 0, 0, 1, 32'h77, 0, 0,  0, 0, 0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            drive(tv[i].ir, tv[i].dr, tv[i].aok, tv[i].dok, tv[i].rd);
            #2;
            chk($sformatf("tv%0d_breq", i), bus_if.req, tv[i].breq);
            chk($sformatf("tv%0d_baddr", i), bus_if.addr, tv[i].baddr);
            chk($sformatf("tv%0d_iaok", i), inst_if.addr_ok, tv[i].iaok);
            chk($sformatf("tv%0d_daok", i), data_if.addr_ok, tv[i].daok);
            chk($sformatf("tv%0d_idok", i), inst_if.data_ok, tv[i].idok);
            chk($sformatf("tv%0d_ddok", i), data_if.data_ok, tv[i].ddok);
            chk($sformatf("tv%0d_out", i), outstanding, tv[i].out);
            chk($sformatf("tv%0d_irdata", i), inst_if.rdata, tv[i].rd);
            chk($sformatf("tv%0d_drdata", i), data_if.rdata, tv[i].rd);
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        #2;
        chk("orphan_set", orphan_err, 1);
        cyc();
        #2;
        chk("orphan_sticky", orphan_err, 1);
        do_reset();
        #2;
        chk("orphan_clr", orphan_err, 0);

        // Hold: inst grant stays frozen while data_req rises
        do_reset();
        drive(1, 0, 0, 0, 0); #2;
        chk("hold0_breq", bus_if.req, 1);
        chk("hold0_addr", bus_if.addr, IA);
        cyc();
        drive(1, 0, 0, 0, 0); #2;
        chk("hold1_addr", bus_if.addr, IA);
        cyc();
        drive(1, 1, 0, 0, 0); #2;
        chk("hold2_addr", bus_if.addr, IA);
        chk("hold2_daok", data_if.addr_ok, 0);
        cyc();
        drive(1, 1, 1, 0, 0); #2;
        chk("hold3_addr", bus_if.addr, IA);
        chk("hold3_iaok", inst_if.addr_ok, 1);
        chk("hold3_daok", data_if.addr_ok, 0);
        cyc();
        drive(0, 1, 1, 0, 0); #2;
        chk("hold4_addr", bus_if.addr, DA);
        chk("hold4_daok", data_if.addr_ok, 1);
        cyc();
        drive(0, 0, 0, 1, 32'ha); #2;
        chk("hold5_idok", inst_if.data_ok, 1);
        cyc();
        drive(0, 0, 0, 1, 32'hb); #2;
        chk("hold6_ddok", data_if.data_ok, 1);
        cyc();

        // Full: four accepts block the fifth even with a same-cycle pop
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0, 0); #2;
            chk($sformatf("full_acc%0d", i), data_if.addr_ok, 1);
            cyc();
        end
        drive(0, 1, 1, 0, 0); #2;
        chk("full_breq", bus_if.req, 0);
        chk("full_out", outstanding, 4);
        cyc();
        drive(0, 1, 1, 1, 0); #2;
        chk("full_pop_breq", bus_if.req, 0);
        chk("full_pop_ddok", data_if.data_ok, 1);
        chk("full_pop_out", outstanding, 4);
        cyc();
        drive(0, 1, 0, 0, 0); #2;
        chk("full_after_breq", bus_if.req, 1);
        chk("full_after_out", outstanding, 3);
        cyc();

        // Simultaneous push/pop at occupancy 2, wrapping pointers
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(k % 2 == 0, k % 2 == 1, 1, k >= 2, 32'(k)); #2;
            chk($sformatf("pp%0d_out", k), outstanding, (k < 2) ? k : 2);
            chk($sformatf("pp%0d_daok", k), data_if.addr_ok, k % 2);
            if (k >= 2) begin
                chk($sformatf("pp%0d_idok", k), inst_if.data_ok, (k - 2) % 2 == 0);
                chk($sformatf("pp%0d_ddok", k), data_if.data_ok, (k - 2) % 2 == 1);
            end
            cyc();
        end

        // Randomized run against the queue model
        do_reset();
        q.delete();
        lock = -1;
        m_orphan = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit ir, dr, aok, dok, full, ebreq, pop, push;
            int s;
            logic [31:0] rd;
            logic [38:0] ef;
            logic [31:0] ea, ew;
            ir  = ($urandom_range(0, 2) != 0);
            dr  = ($urandom_range(0, 2) == 0);
            aok = ($urandom_range(0, 1) == 1);
            dok = (q.size() > 0) ? ($urandom_range(0, 9) < 4)
                                 : ($urandom_range(0, 49) == 0);
            rd  = $urandom;
            inst_if.addr = $urandom; inst_if.wdata = $urandom;
            inst_if.wr = 1'($urandom); inst_if.size = 2'($urandom);
            inst_if.wstrb = 4'($urandom);
            data_if.addr = $urandom; data_if.wdata = $urandom;
            data_if.wr = 1'($urandom); data_if.size = 2'($urandom);
            data_if.wstrb = 4'($urandom);
            drive(ir, dr, aok, dok, rd);
            if ($urandom_range(0, 499) == 0) begin
                rstn = 1'b0;
                cyc();
                rstn = 1'b1;
                q.delete();
                lock = -1;
                m_orphan = 1'b0;
                continue;
            end
            full = (q.size() == OUT);
            if (lock >= 0) s = lock;
            else if (!full && dr) s = 1;
            else if (!full && ir) s = 0;
            else s = -1;
            ebreq = !full && ((s == 1 && dr) || (s == 0 && ir));
            ea = 0; ew = 0; ef = 0;
            if (s == 1) begin
                ea = data_if.addr; ew = data_if.wdata;
                ef = {32'h0, data_if.wr, data_if.size, data_if.wstrb};
            end else if (s == 0) begin
                ea = inst_if.addr; ew = inst_if.wdata;
                ef = {32'h0, inst_if.wr, inst_if.size, inst_if.wstrb};
            end
            pop  = dok && q.size() > 0;
            push = ebreq && aok;
            #2;
            chk("rnd_breq", bus_if.req, ebreq);
            chk("rnd_addr", bus_if.addr, ea);
            chk("rnd_wdata", bus_if.wdata, ew);
            chk("rnd_ctl", {bus_if.wr, bus_if.size, bus_if.wstrb}, ef[31:0]);
            chk("rnd_iaok", inst_if.addr_ok, push && s == 0);
            chk("rnd_daok", data_if.addr_ok, push && s == 1);
            chk("rnd_idok", inst_if.data_ok, pop && q[0] == 1'b0);
            chk("rnd_ddok", data_if.data_ok, pop && q[0] == 1'b1);
            chk("rnd_out", outstanding, q.size());
            chk("rnd_orphan", orphan_err, m_orphan);
            chk("rnd_rdata", data_if.rdata, rd);
            if (dok && q.size() == 0) m_orphan = 1'b1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(s == 1);
            if (lock >= 0) begin
                if (aok) lock = -1;
            end else if (s >= 0 && !aok) begin
                lock = s;
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Two-master, one-slave arbiter for the core's SRAM-like memory interface. It shares a single SRAM-like bus port between the fetch stage (inst_*) and the Excute stage (data_*). The bus port is consumed by the AXI bridge. The block keeps a grant stable while a request is pending, and tracks outstanding accepted transactions in an in-order owner FIFO so each data_ok/rdata beat reaches the master that issued it.

## Interface
- OUTSTANDING, 4, max accepted-but-unanswered transactions; power of 2, ≥2
- clk  in  1  core clock
- rstn  in  1  reset: synchronous and active-low
- inst_req / data_req  in  1  master request (held until addr_ok)
- inst_wr / data_wr  in  1  1 = write
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
- inst_wstrb / data_wstrb  in  4  byte strobes
- inst_addr / data_addr  in  32  physical address
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  response beat for this master
- inst_rdata / data_rdata  out  32  read data (valid with data_ok)
- bus_req  out  1  request to slave
- bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata  out  1/2/4/32/32  muxed request fields
- bus_addr_ok  in  1  slave accepted request
- bus_data_ok  in  1  slave response beat (in request order)
- bus_rdata  in  32  slave read data
- outstanding  out  $clog2(OUTSTANDING)+1  current owner-FIFO occupancy
- orphan_err  out  1  sticky: bus_data_ok seen with empty FIFO

## Operation
- Grant FSM, states IDLE, HOLD_I, HOLD_D.
- IDLE: if FIFO not full, select data if data_req, else inst if inst_req. Data has fixed priority.
- IDLE with a selection and no bus_addr_ok: go to HOLD_D or HOLD_I.
- HOLD_x: the selection is frozen to master x regardless of the other master's req. Return to IDLE on bus_addr_ok.
- HOLD_x is never preempted. A master that drops req while held is a protocol violation; the FSM stays in HOLD_x and bus_req follows x_req.
- bus_req = selected master's req, and is forced 0 when the FIFO is full.
- When no master is selected, all bus_* request fields are 0.
- x_addr_ok = bus_addr_ok & bus_req & selected==x.
- Owner FIFO: OUTSTANDING entries of 1 bit each (1 = data).
  - Push the selected owner on bus_req & bus_addr_ok.
  - Pop on bus_data_ok & !empty.
  - Simultaneous push and pop: occupancy unchanged; head and tail pointers both advance; pointers wrap modulo OUTSTANDING.
- Full (occupancy == OUTSTANDING) blocks new grants even if a pop occurs in the same cycle.
- Response routing:
  - x_data_ok = bus_data_ok & !empty & head==x.
  - inst_rdata and data_rdata are both driven with bus_rdata unconditionally.
- bus_data_ok with an empty FIFO: ignored, no pop, orphan_err set to 1. orphan_err clears only on reset.

## Timing
- Reset (rstn=0 at a clk edge):
  - FSM → IDLE, FIFO empty, outstanding=0, orphan_err=0.
  - bus_req=0; all addr_ok/data_ok outputs = 0 while inputs are idle.
- Request path is combinational: zero-cycle latency from x_req to bus_req, and from bus_addr_ok to x_addr_ok.
- Response path is combinational: bus_data_ok → x_data_ok in the same cycle.
- A request and the response to an older transaction may complete in the same cycle, for the same or different masters.
- FSM, FIFO and orphan_err update on the rising clk edge only.
- Reset asserted mid-transaction: all pending owners are discarded. Later bus_data_ok beats for those transactions set orphan_err.

## Test plan
- Contention: data_req=inst_req=1, bus_addr_ok=1 in the same cycle → data_addr_ok=1, inst_addr_ok=0, FIFO head=1. Next cycle inst is granted.
- Hold: inst_req alone with bus_addr_ok=0 for 3 cycles (state HOLD_I), then data_req rises in cycle 2 → bus_addr stays inst_addr until bus_addr_ok; inst_addr_ok=1, then data granted next.
- Ordering: accept I, D, I, then return 3 bus_data_ok beats with rdata 0x11, 0x22, 0x33 → inst gets 0x11 then 0x33; data gets 0x22.
- Full: OUTSTANDING=4, accept 4 requests with no responses → bus_req=0 and outstanding=4. One bus_data_ok → outstanding=3; bus_req reasserts the next cycle.
- Simultaneous push and pop at occupancy 2 → occupancy stays 2 and pointers wrap correctly over ≥8 transactions.
- Orphan: bus_data_ok with an empty FIFO → no x_data_ok; orphan_err=1 until rstn=0.
